// File: rtl/iob_clken_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_clken_ctrl_pkg
//  Purpose  : Shared state encoding and default widths for iob_clken_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package iob_clken_ctrl_pkg;

    localparam int C_DIV_W = 16;
    localparam int C_CNT_W = 16;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = C_ST_IDLE,
        ST_RUN  = C_ST_RUN
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iob_clken_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : iob_clken_ctrl_if
//  Purpose  : Config handshake, run control and tick outputs of iob_clken_ctrl.
//             half_o exists only when IOB_CLKEN_CTRL_HALF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface iob_clken_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [DIV_W-1:0] cfg_div_i;
    logic [CNT_W-1:0] cfg_cnt_i;
    logic             start_i;
    logic             stop_i;
    logic             busy_o;
    logic             tick_o;
    logic [CNT_W-1:0] tick_cnt_o;
    logic             done_o;
`ifdef IOB_CLKEN_CTRL_HALF_EN
    logic             half_o;
`endif

    modport master (
        output cfg_valid_i, cfg_div_i, cfg_cnt_i, start_i, stop_i,
        input  cfg_ready_o, busy_o, tick_o, tick_cnt_o, done_o
`ifdef IOB_CLKEN_CTRL_HALF_EN
        , input half_o
`endif
    );

    modport slave (
        input  cfg_valid_i, cfg_div_i, cfg_cnt_i, start_i, stop_i,
        output cfg_ready_o, busy_o, tick_o, tick_cnt_o, done_o
`ifdef IOB_CLKEN_CTRL_HALF_EN
        , output half_o
`endif
    );

endinterface
`default_nettype wire

// File: rtl/iob_clken_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : iob_clken_prescaler
//  Purpose  : Divisor counter that wraps on compare-to-div and decodes the tick
//             (and, with IOB_CLKEN_CTRL_HALF_EN, the mid-period half strobe).
//  Revision : 1.0 - initial release
// ============================================================================
module iob_clken_prescaler #(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [DIV_W-1:0] i_div,
`ifdef IOB_CLKEN_CTRL_HALF_EN
    output logic                  o_half,
`endif
    output logic                  o_tick
);

    logic [DIV_W-1:0] r_count;
    logic             w_hit;

    assign w_hit = (r_count == i_div);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_hit ? '0 : r_count + DIV_W'(1);
        end
    end

    // Decodes qualify on enable so both strobes stay low outside RUN.
    assign o_tick = i_en && w_hit;
`ifdef IOB_CLKEN_CTRL_HALF_EN
    assign o_half = i_en && (r_count == (i_div >> 1));
`endif

endmodule
`default_nettype wire

// File: rtl/iob_clken_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iob_clken_ctrl
//  Purpose  : Programmable clock-enable controller: periodic one-cycle ticks,
//             optional burst length, done pulse. Option: IOB_CLKEN_CTRL_HALF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_clken_ctrl
    import iob_clken_ctrl_pkg::*;
#(
    parameter int DIV_W = C_DIV_W,
    parameter int CNT_W = C_CNT_W
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    iob_clken_ctrl_if.slave  bus
);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_done;

    logic             w_run;
    logic             w_start;
    logic             w_tick;
    logic             w_last;
    logic [CNT_W-1:0] w_tick_cnt_nxt;

    assign w_run          = (r_state == ST_RUN);
    assign w_start        = !w_run && bus.start_i;
    assign w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
    // Final tick of a finite burst; completion takes priority over stop.
    assign w_last         = (r_cnt != '0) && w_tick && (w_tick_cnt_nxt == r_cnt);

    iob_clken_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_clr  (w_start),
        .i_en   (w_run),
        .i_div  (r_div),
`ifdef IOB_CLKEN_CTRL_HALF_EN
        .o_half (bus.half_o),
`endif
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_valid_i) begin
                        r_div <= bus.cfg_div_i;
                        r_cnt <= bus.cfg_cnt_i;
                    end
                    if (bus.start_i) begin
                        r_state    <= ST_RUN;
                        r_tick_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_tick_cnt <= w_tick_cnt_nxt;
                    end
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else if (bus.stop_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready_o = !w_run;
    assign bus.busy_o      = w_run;
    assign bus.tick_o      = w_tick;
    assign bus.tick_cnt_o  = r_tick_cnt;
    assign bus.done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_iob_clken_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob_clken_ctrl
//  Purpose  : Directed and random stimulus for two iob_clken_ctrl instances
//             (16/16 and 8/4 widths) against a period-arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob_clken_ctrl;

    logic        clk     = 1'b0;
    logic        s_rst   = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_start = 1'b0;
    logic        s_stop  = 1'b0;
    logic [15:0] s_div   = '0;
    logic [15:0] s_cnt   = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per instance, cycles spent in RUN and ticks issued since start.
    bit m_run   [2] = '{1'b0, 1'b0};
    bit m_done  [2] = '{1'b0, 1'b0};
    int m_since [2] = '{0, 0};
    int m_ticks [2] = '{0, 0};
    int m_div   [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};
    int dmask   [2] = '{32'hFFFF, 32'hFF};
    int cmask   [2] = '{32'hFFFF, 32'hF};

    always #5 clk = ~clk;

    iob_clken_ctrl_if #(.DIV_W(16), .CNT_W(16)) bus_a ();
    iob_clken_ctrl_if #(.DIV_W(8),  .CNT_W(4))  bus_b ();

    assign bus_a.cfg_valid_i = s_valid;
    assign bus_a.cfg_div_i   = s_div;
    assign bus_a.cfg_cnt_i   = s_cnt;
    assign bus_a.start_i     = s_start;
    assign bus_a.stop_i      = s_stop;
    assign bus_b.cfg_valid_i = s_valid;
    assign bus_b.cfg_div_i   = s_div[7:0];
    assign bus_b.cfg_cnt_i   = s_cnt[3:0];
    assign bus_b.start_i     = s_start;
    assign bus_b.stop_i      = s_stop;

    iob_clken_ctrl #(.DIV_W(16), .CNT_W(16)) u_dut_a (
        .clk_i (clk),
        .rst_i (s_rst),
        .bus   (bus_a)
    );

    iob_clken_ctrl #(.DIV_W(8), .CNT_W(4)) u_dut_b (
        .clk_i (clk),
        .rst_i (s_rst),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_tick(input int k);
        return m_run[k] && ((m_since[k] % (m_div[k] + 1)) == m_div[k]);
    endfunction

    function automatic bit exp_half(input int k);
        return m_run[k] && ((m_since[k] % (m_div[k] + 1)) == (m_div[k] >> 1));
    endfunction

    task automatic model_step();
        bit t;
        for (int k = 0; k < 2; k++) begin
            if (s_rst) begin
                m_run[k] = 0; m_done[k] = 0; m_since[k] = 0;
                m_ticks[k] = 0; m_div[k] = 0; m_cnt[k] = 0;
            end else if (!m_run[k]) begin
                m_done[k] = 0;
                if (s_valid) begin
                    m_div[k] = int'(s_div) & dmask[k];
                    m_cnt[k] = int'(s_cnt) & cmask[k];
                end
                if (s_start) begin
                    m_run[k] = 1; m_since[k] = 0; m_ticks[k] = 0;
                end
            end else begin
                m_done[k] = 0;
                t = exp_tick(k);
                if (t) m_ticks[k]++;
                if (m_cnt[k] != 0 && t && ((m_ticks[k] & cmask[k]) == m_cnt[k])) begin
                    m_run[k] = 0; m_done[k] = 1;
                end else if (s_stop) begin
                    m_run[k] = 0;
                end
                m_since[k]++;
            end
        end
    endtask

    task automatic compare_one(input int k, input string p, input logic rdy, input logic busy,
                               input logic tick, input logic done,
`ifdef IOB_CLKEN_CTRL_HALF_EN
                               input logic half,
`endif
                               input logic [15:0] tcnt);
        check_eq({p, "_ready"},    32'(rdy),  32'(!m_run[k]));
        check_eq({p, "_busy"},     32'(busy), 32'(m_run[k]));
        check_eq({p, "_tick"},     32'(tick), 32'(exp_tick(k)));
        check_eq({p, "_done"},     32'(done), 32'(m_done[k]));
        check_eq({p, "_tick_cnt"}, 32'(tcnt), m_ticks[k] & cmask[k]);
`ifdef IOB_CLKEN_CTRL_HALF_EN
        check_eq({p, "_half"},     32'(half), 32'(exp_half(k)));
`endif
    endtask

    task automatic check_all();
        compare_one(0, "a", bus_a.cfg_ready_o, bus_a.busy_o, bus_a.tick_o, bus_a.done_o,
`ifdef IOB_CLKEN_CTRL_HALF_EN
                    bus_a.half_o,
`endif
                    bus_a.tick_cnt_o);
        compare_one(1, "b", bus_b.cfg_ready_o, bus_b.busy_o, bus_b.tick_o, bus_b.done_o,
`ifdef IOB_CLKEN_CTRL_HALF_EN
                    bus_b.half_o,
`endif
                    {12'd0, bus_b.tick_cnt_o});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic rst, input logic valid, input logic [15:0] div,
                         input logic [15:0] cnt, input logic start, input logic stop);
        s_rst = rst; s_valid = valid; s_div = div; s_cnt = cnt; s_start = start; s_stop = stop;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        step();
        step();
        check_eq("rst_ready",    32'(bus_a.cfg_ready_o), 32'd1);
        check_eq("rst_tick_cnt", 32'(bus_a.tick_cnt_o),  32'd0);

        // Burst of 4 ticks, period 4.
        drive(0, 1, 3, 4, 0, 0); step();
        drive(0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            check_eq("t1_tick", 32'(bus_a.tick_o), 32'((k % 4) == 0));
            step();
        end
        check_eq("t1_done",     32'(bus_a.done_o),     32'd1);
        check_eq("t1_busy",     32'(bus_a.busy_o),     32'd0);
        check_eq("t1_tick_cnt", 32'(bus_a.tick_cnt_o), 32'd4);
        step();
        check_eq("t1_done_end", 32'(bus_a.done_o),     32'd0);

        // Continuous div=0, stop after 10 RUN cycles.
        drive(0, 1, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (10) step();
        drive(0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        check_eq("t2_tick_cnt", 32'(bus_a.tick_cnt_o), 32'd11);
        check_eq("t2_busy",     32'(bus_a.busy_o),     32'd0);
        check_eq("t2_done",     32'(bus_a.done_o),     32'd0);

        // Stop on the final burst tick: completion wins.
        drive(0, 1, 1, 3, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) step();
        check_eq("t3_tick", 32'(bus_a.tick_o), 32'd1);
        drive(0, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        check_eq("t3_done",     32'(bus_a.done_o),     32'd1);
        check_eq("t3_tick_cnt", 32'(bus_a.tick_cnt_o), 32'd3);
        step();
        check_eq("t3_done_end", 32'(bus_a.done_o), 32'd0);

        // Config stalled during RUN, accepted afterwards.
        drive(0, 1, 2, 3, 1, 0); step();
        drive(0, 1, 7, 0, 0, 0);
        check_eq("t4_ready_run", 32'(bus_a.cfg_ready_o), 32'd0);
        repeat (9) step();
        check_eq("t4_done",      32'(bus_a.done_o),      32'd1);
        check_eq("t4_ready_idle", 32'(bus_a.cfg_ready_o), 32'd1);
        step();
        drive(0, 0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (7) step();
        check_eq("t4_new_div_tick", 32'(bus_a.tick_o), 32'd1);
        drive(0, 0, 0, 0, 0, 1); step();

        // Reset mid-burst.
        drive(0, 1, 2, 5, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (6) step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        check_eq("t5_busy",     32'(bus_a.busy_o),      32'd0);
        check_eq("t5_tick_cnt", 32'(bus_a.tick_cnt_o),  32'd0);
        check_eq("t5_ready",    32'(bus_a.cfg_ready_o), 32'd1);
        check_eq("t5_done",     32'(bus_a.done_o),      32'd0);

        // Tick counter wrap on the 4-bit instance.
        drive(0, 1, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (20) step();
        check_eq("t6_wrap_b", 32'(bus_b.tick_cnt_o), 32'd4);
        check_eq("t6_full_a", 32'(bus_a.tick_cnt_o), 32'd20);
        drive(0, 0, 0, 0, 0, 1); step();
`ifdef IOB_CLKEN_CTRL_HALF_EN
        drive(0, 1, 5, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        check_eq("t6_half", 32'(bus_a.half_o), 32'd1);
        drive(0, 0, 0, 0, 0, 1); step();
`endif

        for (int i = 0; i < 2000; i++) begin
            s_rst   = ($urandom_range(99) == 0);
            s_valid = ($urandom_range(9) < 3);
            s_div   = ($urandom_range(3) == 0) ? 16'($urandom_range(12)) : 16'($urandom_range(3));
            s_cnt   = 16'($urandom_range(6));
            s_start = ($urandom_range(4) == 0);
            s_stop  = ($urandom_range(29) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
